// File: rtl/rupt_pkg.sv
// rupt_pkg: shared definitions for the rupt priority controller.
//   rupt_state_t     controller state encoding (IDLE, GRANT, SERVICE)
//   RUPT_BASE_DEF    default vector address of source 0 (12'o4000)
//   RUPT_STRIDE_DEF  default address step between vectors
//   idx_w(n)         index width for n sources, never less than 1
package rupt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2
    } rupt_state_t;

    localparam int RUPT_BASE_DEF   = 'o4000;
    localparam int RUPT_STRIDE_DEF = 4;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rupt_prio_enc.sv
// rupt_prio_enc: fixed-priority encoder, lowest set index wins. Purely combinational.
// Ports:
//   i_req  in   N    request vector
//   o_idx  out  IW   index of the lowest set bit (0 when none set)
//   o_any  out  1    1 when any request bit is set
module rupt_prio_enc #(
    parameter int N  = 10,
    parameter int IW = 4
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IW'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rupt_priority_ctrl.sv
// rupt_priority_ctrl: parametrised rupt priority controller.
//   Latches per-source rupt request pulses, offers a rupt to the sequence
//   generator via ruptor_, serves the vector address on an rrpa strobe and
//   tracks rupt-in-service until resume. Adds sticky per-source lost flags
//   and a sticky spurious-grant flag.
// Build option: RUPT_MASK_EN -- adds a writable per-source enable mask
//   (mask_we/mask_wd). Without it the mask is constant all-ones and
//   mask_we/mask_wd are ignored.
// Ports:
//   CLOCK      in   system clock, rising edge
//   rst_       in   asynchronous active-low reset
//   rupt_req   in   NRUPT per-source request pulses
//   inhint     in   1 = rupts inhibited (blocks offer only)
//   ovf_       in   0 = overflow in A (blocks offer)
//   gojam      in   synchronous restart
//   rrpa       in   grant strobe from the core
//   resume     in   end of rupt service
//   lost_clr   in   clears lost flags and spur
//   mask_we    in   mask write strobe
//   mask_wd    in   mask write data, 1 = enabled
//   ruptor_    out  0 = rupt offered
//   rptad      out  vector address, valid with rptad_vld
//   rptad_vld  out  one-cycle grant pulse
//   rupt_idx   out  index of the rupt in service
//   in_rupt    out  1 while in service
//   pend       out  latched requests
//   lost       out  sticky: request arrived while already pending
//   spur       out  sticky: rrpa arrived with nothing offered
//
// state   | meaning
// IDLE    | waiting; offers a rupt when one is pending, enabled and not blocked
// GRANT   | vector address presented for one cycle
// SERVICE | rupt in service; no further offers until resume
module rupt_priority_ctrl
    import rupt_pkg::*;
#(
    parameter int NRUPT  = 10,
    parameter int ADDR_W = 12,
    parameter int BASE   = RUPT_BASE_DEF,
    parameter int STRIDE = RUPT_STRIDE_DEF,
    localparam int IW    = idx_w(NRUPT)
) (
    input  logic              CLOCK,
    input  logic              rst_,
    input  logic [NRUPT-1:0]  rupt_req,
    input  logic              inhint,
    input  logic              ovf_,
    input  logic              gojam,
    input  logic              rrpa,
    input  logic              resume,
    input  logic              lost_clr,
    input  logic              mask_we,
    input  logic [NRUPT-1:0]  mask_wd,
    output logic              ruptor_,
    output logic [ADDR_W-1:0] rptad,
    output logic              rptad_vld,
    output logic [IW-1:0]     rupt_idx,
    output logic              in_rupt,
    output logic [NRUPT-1:0]  pend,
    output logic [NRUPT-1:0]  lost,
    output logic              spur
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_GRANT   = GRANT;
    localparam logic [1:0] ST_SERVICE = SERVICE;

    logic [1:0]        r_state;
    logic [NRUPT-1:0]  r_pend;
    logic [NRUPT-1:0]  r_lost;
    logic              r_spur;
    logic [ADDR_W-1:0] r_rptad;
    logic              r_rptad_vld;
    logic [IW-1:0]     r_rupt_idx;
    logic              r_in_rupt;

    logic [NRUPT-1:0]  w_mask;
    logic [NRUPT-1:0]  w_avail;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic              w_offer;
    logic              w_grant;
    logic [NRUPT-1:0]  w_grant_oh;
    logic [NRUPT-1:0]  w_lost_set;
    logic              w_spur_set;
    logic [ADDR_W-1:0] w_addr;

`ifdef RUPT_MASK_EN
    logic [NRUPT-1:0] r_mask;

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_mask <= '1;
        end else if (gojam) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_wd;
        end
    end

    assign w_mask = r_mask;
`else
    logic w_unused_mask;
    assign w_unused_mask = ^{mask_we, mask_wd};
    assign w_mask        = '1;
`endif

    // Masked sources keep latching; they are only hidden from the encoder.
    assign w_avail = r_pend & w_mask;

    rupt_prio_enc #(
        .N  (NRUPT),
        .IW (IW)
    ) u_enc (
        .i_req (w_avail),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_offer    = (r_state == ST_IDLE) & w_any & ~inhint & ovf_;
    assign w_grant    = w_offer & rrpa;
    assign w_grant_oh = w_grant ? (NRUPT'(1) << w_idx) : '0;
    assign w_addr     = ADDR_W'(BASE) + ADDR_W'(STRIDE) * ADDR_W'(w_idx);

    // A request coinciding with the grant of the same source re-arms pend
    // rather than counting as lost.
    assign w_lost_set = rupt_req & r_pend & ~w_grant_oh;
    assign w_spur_set = (r_state == ST_IDLE) & rrpa & ~w_offer;

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_pend <= '0;
            r_lost <= '0;
            r_spur <= 1'b0;
        end else if (gojam) begin
            r_pend <= '0;
            r_lost <= '0;
            r_spur <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_grant_oh) | rupt_req;
            r_lost <= (lost_clr ? '0 : r_lost) | w_lost_set;
            r_spur <= (r_spur & ~lost_clr) | w_spur_set;
        end
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_state     <= ST_IDLE;
            r_rptad     <= '0;
            r_rptad_vld <= 1'b0;
            r_rupt_idx  <= '0;
            r_in_rupt   <= 1'b0;
        end else if (gojam) begin
            r_state     <= ST_IDLE;
            r_rptad     <= '0;
            r_rptad_vld <= 1'b0;
            r_rupt_idx  <= '0;
            r_in_rupt   <= 1'b0;
        end else begin
            r_rptad_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_rptad     <= w_addr;
                        r_rptad_vld <= 1'b1;
                        r_rupt_idx  <= w_idx;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_in_rupt <= 1'b1;
                    r_state   <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (resume) begin
                        r_in_rupt <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ruptor_   = ~w_offer;
    assign rptad     = r_rptad;
    assign rptad_vld = r_rptad_vld;
    assign rupt_idx  = r_rupt_idx;
    assign in_rupt   = r_in_rupt;
    assign pend      = r_pend;
    assign lost      = r_lost;
    assign spur      = r_spur;

endmodule
